nibble_prog_mem: RTL and testbench

NIBBLE_PROG_MEM -- requirements
Module: nibble_prog_mem

---
 rtl/nibble_prog_mem_pkg.sv | 17 +
 rtl/nibble_prog_mem_loader.sv | 57 +++++
 rtl/nibble_prog_mem.sv | 59 +++++
 tb/tb_nibble_prog_mem.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/nibble_prog_mem_pkg.sv
// Shared types and constants for the nibble program memory and its loader.
package nibble_prog_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int               MEM_DEPTH   = 16;
  localparam int               ADDR_W      = 4;
  localparam int               CNT_W       = 5;
  localparam logic [CNT_W-1:0] FULL_COUNT  = 5'd16;
  localparam logic [7:0]       IDLE_INSTR  = 8'h00;
  localparam logic             PHASE_FETCH = 1'b0;

endpackage

// File: rtl/nibble_prog_mem_loader.sv
// Load/run control FSM: owns the write pointer, byte count and loader handshake.
module nibble_prog_mem_loader
  import nibble_prog_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              cpu_run,
  output logic              run_entry,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CNT_W-1:0]  load_count
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] wr_ptr;
  logic              load_entry;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = load_en ? ST_LOAD : ST_RUN;
      ST_LOAD: if (!load_en || (load_count == FULL_COUNT)) state_nx = ST_RUN;
      ST_RUN:  if (load_en) state_nx = ST_LOAD;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Once 16 bytes are in, ready drops so a 17th byte can never be taken.
  assign load_ready = (state == ST_LOAD) && (load_count < FULL_COUNT);
  assign wr_en      = load_valid && load_ready;
  assign wr_addr    = wr_ptr;
  assign cpu_run    = (state == ST_RUN);
  assign load_entry = (state != ST_LOAD) && (state_nx == ST_LOAD);
  assign run_entry  = (state != ST_RUN) && (state_nx == ST_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      load_count <= '0;
    end else begin
      state <= state_nx;
      if (load_entry) begin
        wr_ptr     <= '0;
        load_count <= '0;
      end else if (wr_en) begin
        wr_ptr     <= wr_ptr + 1'b1;
        load_count <= load_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nibble_prog_mem.sv
// 16x8 program store for a nibble CPU: loader-written, read combinationally by pc_in in RUN.
module nibble_prog_mem
  import nibble_prog_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              phase_in,
  output logic [7:0]        instr_out,
  input  logic              load_en,
  input  logic [7:0]        load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              cpu_run,
  output logic [CNT_W-1:0]  load_count,
  output logic [7:0]        fetch_count
);

  logic [7:0]        mem [MEM_DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              run_entry;

  nibble_prog_mem_loader u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .cpu_run    (cpu_run),
    .run_entry  (run_entry),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .load_count (load_count)
  );

  // Reset clears the whole store so an interrupted load leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= IDLE_INSTR;
    end else if (wr_en) begin
      mem[wr_addr] <= load_data;
    end
  end

  // Reads are gated to RUN, so a same-cycle write/read collision cannot happen.
  assign instr_out = cpu_run ? mem[pc_in] : IDLE_INSTR;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (run_entry) begin
      fetch_count <= '0;
    end else if (cpu_run && (phase_in == PHASE_FETCH) && (fetch_count != 8'hFF)) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_nibble_prog_mem.sv
// Directed bench for nibble_prog_mem: load, run, fetch saturation, reload and reset mid-load.
module tb_nibble_prog_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pc_in;
  logic       phase_in;
  logic [7:0] instr_out;
  logic       load_en;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       cpu_run;
  logic [4:0] load_count;
  logic [7:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_prog_mem dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .phase_in    (phase_in),
    .instr_out   (instr_out),
    .load_en     (load_en),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .cpu_run     (cpu_run),
    .load_count  (load_count),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    pc_in = addr;
    #1;
    chk(tag, {24'h0, instr_out}, {24'h0, exp});
  endtask

  int exp_fc;

  initial begin
    rst_n = 1'b0; pc_in = 4'd0; phase_in = 1'b1;
    load_en = 1'b0; load_data = 8'h00; load_valid = 1'b0;
    tick(); tick();
    chk("rst_cpu_run",     {31'h0, cpu_run},     32'd0);
    chk("rst_load_ready",  {31'h0, load_ready},  32'd0);
    chk("rst_instr_out",   {24'h0, instr_out},   32'h00);
    chk("rst_load_count",  {27'h0, load_count},  32'd0);
    chk("rst_fetch_count", {24'h0, fetch_count}, 32'd0);

    // full 16-byte load straight out of reset
    rst_n = 1'b1; load_en = 1'b1;
    tick();
    chk("load_entry_ready", {31'h0, load_ready}, 32'd1);
    chk("load_entry_run",   {31'h0, cpu_run},    32'd0);
    for (int i = 0; i < 16; i++) begin
      load_data = 8'h10 + 8'(i); load_valid = 1'b1;
      tick();
    end
    chk("full_load_count", {27'h0, load_count}, 32'd16);
    chk("full_load_ready", {31'h0, load_ready}, 32'd0);
    chk("full_cpu_run",    {31'h0, cpu_run},    32'd0);
    chk("full_instr_idle", {24'h0, instr_out},  32'h00);
    load_data = 8'hEE;
    tick();
    load_en = 1'b0; load_valid = 1'b0;
    chk("full_to_run",     {31'h0, cpu_run},     32'd1);
    chk("run_load_count",  {27'h0, load_count},  32'd16);
    chk("run_fetch_clear", {24'h0, fetch_count}, 32'd0);
    rd("run_pc5", 4'd5, 8'h15);
    rd("no17th_mem0", 4'd0, 8'h10);
    rd("run_pc15", 4'd15, 8'h1F);

    // fetch counting and zero-latency reads across the 15->0 wrap
    exp_fc = 0;
    for (int i = 0; i < 600; i++) begin
      phase_in = i[0];
      rd("fetch_instr", i[3:0], 8'h10 + 8'(i[3:0]));
      tick();
      if (i[0] == 1'b0 && exp_fc < 255) exp_fc++;
      chk("fetch_count", {24'h0, fetch_count}, exp_fc);
    end
    chk("fetch_sat", {24'h0, fetch_count}, 32'd255);
    phase_in = 1'b1;

    // reload a single byte over the existing program
    load_en = 1'b1;
    tick();
    chk("reload_cpu_run",    {31'h0, cpu_run},    32'd0);
    chk("reload_instr_idle", {24'h0, instr_out},  32'h00);
    chk("reload_count_clr",  {27'h0, load_count}, 32'd0);
    load_data = 8'h77; load_valid = 1'b1;
    tick();
    chk("reload_count1", {27'h0, load_count}, 32'd1);
    load_valid = 1'b0; load_en = 1'b0;
    tick();
    chk("reload_run",       {31'h0, cpu_run},    32'd1);
    chk("reload_count_hold", {27'h0, load_count}, 32'd1);
    rd("reload_mem0", 4'd0, 8'h77);
    for (int i = 1; i < 16; i++) rd("reload_keep", 4'(i), 8'h10 + 8'(i));

    // reset in the middle of a load discards everything
    load_en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      load_data = 8'hA0 + 8'(i); load_valid = 1'b1;
      tick();
    end
    chk("mid_load_count", {27'h0, load_count}, 32'd8);
    rst_n = 1'b0; load_valid = 1'b0; load_en = 1'b0;
    tick();
    chk("midrst_cpu_run",     {31'h0, cpu_run},     32'd0);
    chk("midrst_load_ready",  {31'h0, load_ready},  32'd0);
    chk("midrst_instr",       {24'h0, instr_out},   32'h00);
    chk("midrst_load_count",  {27'h0, load_count},  32'd0);
    chk("midrst_fetch_count", {24'h0, fetch_count}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("first_edge_run", {31'h0, cpu_run}, 32'd1);
    for (int i = 0; i < 16; i++) rd("midrst_mem_clr", 4'(i), 8'h00);

    // partial load of three bytes into a cleared store
    load_en = 1'b1;
    tick();
    load_valid = 1'b1;
    load_data = 8'hAA; tick();
    load_data = 8'hBB; tick();
    load_data = 8'hCC; tick();
    load_valid = 1'b0; load_en = 1'b0;
    tick();
    chk("partial_run",   {31'h0, cpu_run},    32'd1);
    chk("partial_count", {27'h0, load_count}, 32'd3);
    rd("partial_pc0", 4'd0, 8'hAA);
    rd("partial_pc2", 4'd2, 8'hCC);
    rd("partial_pc3", 4'd3, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
